// File: rtl/fnv1a_unwind.sv
// Sequential inverse of the FNV-1a lane step: recovers h from h' = (h ^ m) * PRIME, one modifier per two cycles.
// Optional expected-value compare is enabled by defining FNV1A_UNWIND_CHECK_EN.
module fnv1a_unwind #(
  parameter int unsigned COUNT_W       = 8,
  parameter logic [31:0] FNV_PRIME_INV = 32'h359C449B
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_hash,
  input  logic [COUNT_W-1:0] cmd_count,
`ifdef FNV1A_UNWIND_CHECK_EN
  input  logic [31:0]        cmd_expect,
`endif
  input  logic               mod_valid,
  output logic               mod_ready,
  input  logic [31:0]        mod_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_value,
`ifdef FNV1A_UNWIND_CHECK_EN
  output logic               res_match,
`endif
  output logic               busy
);

  localparam logic [31:0] FNV_PRIME = 32'h01000193;
  localparam logic [31:0] INV_PROD  = FNV_PRIME * FNV_PRIME_INV;

  if (INV_PROD != 32'd1) begin : g_bad_inverse
    $error("FNV_PRIME_INV is not the inverse of FNV_PRIME mod 2^32");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MOD = 2'd1,
    STEP     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        h_q, h_d;
  logic [31:0]        m_q, m_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        step_val;

  // Low 32 bits of the product only; the upper half is never needed.
  assign step_val = (h_q * FNV_PRIME_INV) ^ m_q;

`ifdef FNV1A_UNWIND_CHECK_EN
  logic [31:0] exp_q, exp_d;
  logic        match_q, match_d;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
`ifdef FNV1A_UNWIND_CHECK_EN
    exp_d   = exp_q;
    match_d = match_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          h_d   = cmd_hash;
          cnt_d = cmd_count;
`ifdef FNV1A_UNWIND_CHECK_EN
          exp_d   = cmd_expect;
          match_d = (cmd_hash == cmd_expect);
`endif
          state_d = (cmd_count != '0) ? WAIT_MOD : DONE;
        end
      end
      WAIT_MOD: begin
        if (mod_valid) begin
          m_d     = mod_data;
          state_d = STEP;
        end
      end
      STEP: begin
        h_d   = step_val;
        cnt_d = cnt_q - COUNT_W'(1);
`ifdef FNV1A_UNWIND_CHECK_EN
        match_d = (step_val == exp_q);
`endif
        state_d = (cnt_q == COUNT_W'(1)) ? DONE : WAIT_MOD;
      end
      DONE: begin
        if (res_ready) begin
`ifdef FNV1A_UNWIND_CHECK_EN
          match_d = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FNV1A_UNWIND_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

  assign res_match = match_q;
`endif

  // Every output is a decode of registered state.
  assign cmd_ready = (state_q == IDLE);
  assign mod_ready = (state_q == WAIT_MOD);
  assign res_valid = (state_q == DONE);
  assign res_value = h_q;
  assign busy      = (state_q != IDLE);

endmodule
